// File: rtl/mha_bram_pkg.sv
// Shared types for the MHA Q/K/V/O matrix store and the arbiter in front of it.
package mha_bram_pkg;

  localparam int TILE_DIM = 16;
  localparam int ELEM_W   = 8;
  localparam int MAT_W    = 2;
  localparam int LINE_W   = 6;
  localparam int COL_W    = 3;

  typedef enum logic [MAT_W-1:0] {
    MAT_Q = 2'd0,
    MAT_K = 2'd1,
    MAT_V = 2'd2,
    MAT_O = 2'd3
  } sel_mat_e;

  typedef logic [TILE_DIM-1:0][TILE_DIM-1:0][ELEM_W-1:0] tile_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after the pointer, with wrap.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IW-1:0]    gnt_idx
);

  int   k;
  logic found;

  // Walk the requesters starting from the pointer and keep only the first hit.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        gnt_oh[k] = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/bram_req_arbiter.sv
// Round-robin arbiter sharing one bram_manager between several MHA engines,
// sequencing the manager's enable handshake and guarding it with a watchdog.
module bram_req_arbiter
  import mha_bram_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                         I_CLK,
  input  logic                         I_RST_N,
  input  logic [N_REQ-1:0]             I_REQ,
  input  logic [N_REQ-1:0]             I_REQ_WR,
  input  logic [N_REQ-1:0][MAT_W-1:0]  I_REQ_SEL_MAT,
  input  logic [N_REQ-1:0][LINE_W-1:0] I_REQ_SEL_LINE,
  input  logic [N_REQ-1:0][COL_W-1:0]  I_REQ_SEL_COL,
  input  tile_t [N_REQ-1:0]            I_REQ_MAT,
  output logic [N_REQ-1:0]             O_GNT,
  output logic [N_REQ-1:0]             O_ACK,
  output logic                         O_ERR,
  output tile_t                        O_RD_MAT,
  output logic                         O_BM_RD_ENA,
  output logic                         O_BM_WR_ENA,
  output sel_mat_e                     O_BM_SEL_MAT,
  output logic [LINE_W-1:0]            O_BM_SEL_LINE,
  output logic [COL_W-1:0]             O_BM_SEL_COL,
  output tile_t                        O_BM_MAT,
  input  logic                         I_BM_VLD,
  input  tile_t                        I_BM_MAT,
  input  logic                         I_BM_WR_DONE
);

  localparam int            IW      = $clog2(N_REQ);
  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] win_oh;
  logic [N_REQ-1:0] pick_oh;
  logic             op_wr;
  logic             err_flag;
  logic             load;
  logic             done;
  logic             tmo;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_inc;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req     (I_REQ),
    .ptr     (ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  // State register; reset drops the enables immediately, even mid-transaction.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state: issue on any request, finish on the matching strobe or watchdog, one gap cycle.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (|I_REQ) begin
          load      = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        done = op_wr ? I_BM_WR_DONE : I_BM_VLD;
        if (done) begin
          state_nxt = ST_GAP;
        end else if (cnt_inc == CNT_MAX) begin
          tmo       = 1'b1;
          state_nxt = ST_GAP;
        end
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the winner's operation and fields so the manager sees them stable for the whole op.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      win_oh        <= '0;
      win_idx       <= '0;
      op_wr         <= 1'b0;
      O_BM_SEL_MAT  <= MAT_Q;
      O_BM_SEL_LINE <= '0;
      O_BM_SEL_COL  <= '0;
      O_BM_MAT      <= '0;
    end else if (load) begin
      win_oh        <= pick_oh;
      win_idx       <= pick_idx;
      op_wr         <= I_REQ_WR[pick_idx];
      O_BM_SEL_MAT  <= sel_mat_e'(I_REQ_SEL_MAT[pick_idx]);
      O_BM_SEL_LINE <= I_REQ_SEL_LINE[pick_idx];
      O_BM_SEL_COL  <= I_REQ_SEL_COL[pick_idx];
      O_BM_MAT      <= I_REQ_MAT[pick_idx];
    end
  end

  // Watchdog counter and error flag, both restarted at every issue.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      cnt      <= '0;
      err_flag <= 1'b0;
    end else if (load) begin
      cnt      <= '0;
      err_flag <= 1'b0;
    end else if (state == ST_BUSY) begin
      cnt <= cnt_inc;
      if (tmo) err_flag <= 1'b1;
    end
  end

  // Read tile is captured only on a completed read, so writes and timeouts leave it alone.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N)                                     O_RD_MAT <= '0;
    else if (state == ST_BUSY && done && !op_wr)      O_RD_MAT <= I_BM_MAT;
  end

  // Advance the round-robin pointer past the requester just served.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N)               ptr <= '0;
    else if (state == ST_GAP)   ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
  end

  assign O_GNT       = (state != ST_IDLE) ? win_oh : '0;
  assign O_ACK       = (state == ST_GAP) ? win_oh : '0;
  assign O_ERR       = (state == ST_GAP) && err_flag;
  assign O_BM_RD_ENA = (state == ST_BUSY) && !op_wr;
  assign O_BM_WR_ENA = (state == ST_BUSY) && op_wr;

endmodule

// File: tb/tb_bram_req_arbiter.sv
// Randomized bench for bram_req_arbiter with a bench-side manager stub and a
// transaction-level reference model of arbitration, timing and data.
module tb_bram_req_arbiter;
  import mha_bram_pkg::*;

  localparam int N   = 3;
  localparam int TMO = 15;

  logic              clk = 1'b0;
  logic              rstN = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      reqWr = '0;
  logic [N-1:0][1:0] reqSelMat = '0;
  logic [N-1:0][5:0] reqLine = '0;
  logic [N-1:0][2:0] reqCol = '0;
  tile_t [N-1:0]     reqMat = '0;
  logic [N-1:0]      gnt;
  logic [N-1:0]      ack;
  logic              err;
  tile_t             rdMat;
  logic              rdEna;
  logic              wrEna;
  logic [1:0]        bmSelMat;
  logic [5:0]        bmSelLine;
  logic [2:0]        bmSelCol;
  tile_t             bmMatOut;
  logic              bmVld = 1'b0;
  tile_t             bmMatIn = '0;
  logic              bmWrDone = 1'b0;

  int    vectors = 0;
  int    miscompares = 0;
  int    reqLat[N];
  int    rrPtr = 0;
  bit    busy = 1'b0;
  int    curWin = 0;
  int    enaRun = 0;
  int    expEnd = 0;
  bit    expErr = 1'b0;
  int    idleWait = 0;
  int    reissuePct = 0;
  tile_t expRd = '0;
  tile_t zeroTile = '0;
  tile_t refMem[int];
  tile_t stubMem[int];

  always #5 clk = ~clk;

  bram_req_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .I_CLK          (clk),
    .I_RST_N        (rstN),
    .I_REQ          (req),
    .I_REQ_WR       (reqWr),
    .I_REQ_SEL_MAT  (reqSelMat),
    .I_REQ_SEL_LINE (reqLine),
    .I_REQ_SEL_COL  (reqCol),
    .I_REQ_MAT      (reqMat),
    .O_GNT          (gnt),
    .O_ACK          (ack),
    .O_ERR          (err),
    .O_RD_MAT       (rdMat),
    .O_BM_RD_ENA    (rdEna),
    .O_BM_WR_ENA    (wrEna),
    .O_BM_SEL_MAT   (bmSelMat),
    .O_BM_SEL_LINE  (bmSelLine),
    .O_BM_SEL_COL   (bmSelCol),
    .O_BM_MAT       (bmMatOut),
    .I_BM_VLD       (bmVld),
    .I_BM_MAT       (bmMatIn),
    .I_BM_WR_DONE   (bmWrDone)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic tile_t defaultTile(input int addr);
    tile_t t;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        t[r][c] = 8'(addr * 7 + r * 16 + c);
    return t;
  endfunction

  function automatic tile_t randomTile();
    logic [2047:0] flat;
    for (int w = 0; w < 64; w++) flat[w*32 +: 32] = $urandom();
    return flat;
  endfunction

  function automatic int diffBytes(input tile_t a, input tile_t b);
    int n;
    n = 0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        if (a[r][c] !== b[r][c]) n++;
    return n;
  endfunction

  function automatic int addrOf(input logic [1:0] m, input logic [5:0] l, input logic [2:0] c);
    return int'(m) * 512 + int'(l) * 8 + int'(c);
  endfunction

  function automatic tile_t refRead(input int a);
    return refMem.exists(a) ? refMem[a] : defaultTile(a);
  endfunction

  function automatic tile_t stubRead(input int a);
    return stubMem.exists(a) ? stubMem[a] : defaultTile(a);
  endfunction

  function automatic logic [N-1:0] onehotOf(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0 && w < N) v[w] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first requester at or after the pointer, wrapping.
  function automatic int pickRr(input logic [N-1:0] seen, input int ptr);
    for (int i = 0; i < N; i++)
      if (seen[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  function automatic int randomLat();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return 0;
    if (s == 1) return TMO;
    if (s == 2) return TMO + 2;
    return $urandom_range(1, 6);
  endfunction

  task automatic applyStimulus(input int i, input logic wr, input logic [1:0] m, input logic [5:0] l,
                               input logic [2:0] c, input int lat, input tile_t t);
    reqWr[i]     = wr;
    reqSelMat[i] = m;
    reqLine[i]   = l;
    reqCol[i]    = c;
    reqMat[i]    = t;
    reqLat[i]    = lat;
    req[i]       = 1'b1;
  endtask

  task automatic randomIssue(input int i);
    applyStimulus(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                  3'($urandom_range(0, 1)), randomLat(), randomTile());
  endtask

  // One clock of the reference model plus the manager stub, sampled 1 ns after the edge.
  task automatic stepCycle();
    logic [N-1:0] seen;
    logic         ena;
    int           a;
    bit           hit;
    @(posedge clk);
    #1;
    seen = req;
    ena  = rdEna | wrEna;
    if (ena) begin
      if (!busy) begin
        curWin = pickRr(seen, rrPtr);
        if (curWin < 0) begin
          checkOutput("spurious_issue", {62'd0, rdEna, wrEna}, 64'd0);
          curWin = 0;
        end
        checkOutput("gnt_issue", gnt, onehotOf(curWin));
        checkOutput("op_wr", {62'd0, wrEna, rdEna}, {62'd0, reqWr[curWin], ~reqWr[curWin]});
        checkOutput("bm_sel", {bmSelMat, bmSelLine, bmSelCol},
                    {reqSelMat[curWin], reqLine[curWin], reqCol[curWin]});
        if (reqWr[curWin]) checkOutput("bm_mat_diff", diffBytes(bmMatOut, reqMat[curWin]), 0);
        busy     = 1'b1;
        enaRun   = 0;
        idleWait = 0;
        expErr   = !(reqLat[curWin] >= 1 && reqLat[curWin] <= TMO);
        expEnd   = expErr ? TMO : reqLat[curWin];
      end else begin
        checkOutput("gnt_hold", gnt, onehotOf(curWin));
      end
      enaRun++;
      checkOutput("ack_busy", ack, 64'd0);
    end else if (busy) begin
      checkOutput("run_len", enaRun, expEnd);
      checkOutput("ack", ack, onehotOf(curWin));
      checkOutput("err", err, expErr);
      checkOutput("gnt_gap", gnt, onehotOf(curWin));
      a = addrOf(reqSelMat[curWin], reqLine[curWin], reqCol[curWin]);
      if (!expErr && !reqWr[curWin]) expRd = refRead(a);
      if (!expErr && reqWr[curWin]) refMem[a] = reqMat[curWin];
      checkOutput("rd_mat_diff", diffBytes(rdMat, expRd), 0);
      rrPtr       = (curWin + 1) % N;
      busy        = 1'b0;
      req[curWin] = 1'b0;
    end else if (req != '0) begin
      idleWait++;
      if (idleWait > 3) begin
        checkOutput("issue_wait", idleWait, 3);
        idleWait = 0;
      end
    end

    bmVld    = 1'b0;
    bmWrDone = 1'b0;
    bmMatIn  = randomTile();
    if (ena && busy) begin
      a   = addrOf(bmSelMat, bmSelLine, bmSelCol);
      hit = (reqLat[curWin] != 0) && (enaRun == reqLat[curWin]);
      if (rdEna) begin
        bmVld    = hit;
        bmWrDone = ($urandom_range(0, 3) == 0);
        if (hit) bmMatIn = stubRead(a);
      end else begin
        bmWrDone = hit;
        bmVld    = ($urandom_range(0, 3) == 0);
        if (hit) stubMem[a] = bmMatOut;
      end
    end else begin
      bmVld    = ($urandom_range(0, 3) == 0);
      bmWrDone = ($urandom_range(0, 3) == 0);
    end

    for (int i = 0; i < N; i++)
      if (!req[i] && $urandom_range(0, 99) < reissuePct) randomIssue(i);
  endtask

  task automatic drain(input int maxCycles);
    int n;
    n = 0;
    while ((req != '0 || busy) && n < maxCycles) begin
      stepCycle();
      n++;
    end
    if (req != '0 || busy) checkOutput("drain_timeout", {60'd0, busy, req}, 64'd0);
  endtask

  initial begin
    tile_t rowTile;
    int    n;
    for (int i = 0; i < N; i++) reqLat[i] = 1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_gnt", gnt, 64'd0);
    checkOutput("rst_ack", ack, 64'd0);
    checkOutput("rst_err", err, 64'd0);
    checkOutput("rst_ena", {62'd0, rdEna, wrEna}, 64'd0);
    checkOutput("rst_bm_sel", {bmSelMat, bmSelLine, bmSelCol}, 64'd0);
    checkOutput("rst_bm_mat", diffBytes(bmMatOut, zeroTile), 0);
    checkOutput("rst_rd_mat", diffBytes(rdMat, zeroTile), 0);
    #1 rstN = 1'b1;

    // Single read, manager answers in the fourth enable cycle.
    applyStimulus(0, 1'b0, 2'd0, 6'd1, 3'd0, 4, randomTile());
    drain(60);

    // Write a tile to O and read it back.
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        rowTile[r][c] = (r % 4 == 0) ? 8'h55 : (r % 4 == 1) ? 8'h66 : (r % 4 == 2) ? 8'h77 : 8'h88;
    applyStimulus(1, 1'b1, 2'd3, 6'd9, 3'd2, 3, rowTile);
    drain(60);
    applyStimulus(1, 1'b0, 2'd3, 6'd9, 3'd2, 2, randomTile());
    drain(60);

    // All requesters held continuously.
    for (int i = 0; i < N; i++)
      applyStimulus(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                    3'd1, $urandom_range(1, 4), randomTile());
    reissuePct = 100;
    repeat (80) stepCycle();
    reissuePct = 0;
    drain(200);

    // Manager never answers, then answers exactly as the watchdog expires.
    applyStimulus(0, 1'b0, 2'd2, 6'd5, 3'd3, 0, randomTile());
    drain(60);
    applyStimulus(2, 1'b0, 2'd1, 6'd7, 3'd4, TMO, randomTile());
    drain(60);

    // Randomized traffic.
    reissuePct = 30;
    repeat (700) stepCycle();
    reissuePct = 0;
    drain(300);

    // Reset in the middle of a stalled read; pointer must come back to 0.
    applyStimulus(1, 1'b0, 2'd0, 6'd2, 3'd0, 2, randomTile());
    drain(60);
    applyStimulus(0, 1'b0, 2'd0, 6'd3, 3'd0, 0, randomTile());
    n = 0;
    while (!busy && n < 10) begin
      stepCycle();
      n++;
    end
    checkOutput("stall_started", busy, 1'b1);
    repeat (3) stepCycle();
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst_mid_ena", {62'd0, rdEna, wrEna}, 64'd0);
    checkOutput("rst_mid_gnt", gnt, 64'd0);
    checkOutput("rst_mid_rd_mat", diffBytes(rdMat, zeroTile), 0);
    busy     = 1'b0;
    rrPtr    = 0;
    expRd    = '0;
    req      = '0;
    bmVld    = 1'b0;
    bmWrDone = 1'b0;
    idleWait = 0;
    repeat (2) @(posedge clk);
    #2 rstN = 1'b1;
    applyStimulus(1, 1'b0, 2'd1, 6'd0, 3'd0, 2, randomTile());
    applyStimulus(2, 1'b0, 2'd2, 6'd0, 3'd0, 2, randomTile());
    drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
